// File: rtl/sdp_ram_arbiter_pkg.sv
// Shared constants and types for the two-requester simple-dual-port RAM arbiter.
package sdp_ram_arbiter_pkg;
    localparam int NUM_REQ    = 2;
    localparam int COLL_CNT_W = 16;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        return NUM_REQ'(1) << id;
    endfunction
endpackage

// File: rtl/sdp_ram_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin grant; ready is combinational from valid and the pointer.
// The pointer moves to the other requester after every granted transfer.
module rr_arbiter_2
    import sdp_ram_arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] valid_i,
    output logic [NUM_REQ-1:0] ready_o,
    output req_id_t            grant_id_o,
    output logic               xfer_o
);
    req_id_t ptr_q, ptr_d;

    always_comb begin
        grant_id_o = ptr_q;
        if (valid_i == 2'b01) begin
            grant_id_o = 1'b0;
        end else if (valid_i == 2'b10) begin
            grant_id_o = 1'b1;
        end
        // Any valid request is always granted, so a transfer happens whenever one is pending.
        xfer_o  = (|valid_i) & ~rst_i;
        ready_o = xfer_o ? id_to_onehot(grant_id_o) : '0;
        ptr_d   = xfer_o ? ~grant_id_o : ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/sdp_ram_arbiter.sv
// Two requesters per side share one SDP RAM; writes and reads are arbitrated independently.
// Optional same-address collision reporting is enabled by SDP_RAM_ARB_COLLISION_EN.
module sdp_ram_arbiter
    import sdp_ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    localparam int BYTE_VALID_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NUM_REQ-1:0]                  wr_valid_i,
    output logic [NUM_REQ-1:0]                  wr_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       wr_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       wr_data_i,
    input  logic [NUM_REQ*BYTE_VALID_WIDTH-1:0] wr_byte_valid_i,
    input  logic [NUM_REQ-1:0]                  rd_valid_i,
    output logic [NUM_REQ-1:0]                  rd_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       rd_addr_i,
    output logic [DATA_WIDTH-1:0]               rd_data_o,
    output logic [NUM_REQ-1:0]                  rd_data_valid_o,
    output logic                                ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]               ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]               ram_wr_data_o,
    output logic [BYTE_VALID_WIDTH-1:0]         ram_wr_byte_valid_o,
    output logic                                ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]               ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]               ram_rd_data_i,
    output logic                                collision_o,
    output logic [COLL_CNT_W-1:0]               collision_cnt_o
);
    req_id_t wr_gid, rd_gid;
    logic    wr_xfer, rd_xfer;

    rr_arbiter_2 u_wr_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (wr_valid_i),
        .ready_o    (wr_ready_o),
        .grant_id_o (wr_gid),
        .xfer_o     (wr_xfer)
    );

    rr_arbiter_2 u_rd_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (rd_valid_i),
        .ready_o    (rd_ready_o),
        .grant_id_o (rd_gid),
        .xfer_o     (rd_xfer)
    );

    logic [ADDR_WIDTH-1:0]       wr_addr_d, rd_addr_d;
    logic [DATA_WIDTH-1:0]       wr_data_d;
    logic [BYTE_VALID_WIDTH-1:0] wr_bv_d;

    assign wr_addr_d = wr_addr_i[wr_gid*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_d = wr_data_i[wr_gid*DATA_WIDTH +: DATA_WIDTH];
    assign wr_bv_d   = wr_byte_valid_i[wr_gid*BYTE_VALID_WIDTH +: BYTE_VALID_WIDTH];
    assign rd_addr_d = rd_addr_i[rd_gid*ADDR_WIDTH +: ADDR_WIDTH];

    logic                        wr_en_q, rd_en_q;
    logic [ADDR_WIDTH-1:0]       wr_addr_q, rd_addr_q;
    logic [DATA_WIDTH-1:0]       wr_data_q;
    logic [BYTE_VALID_WIDTH-1:0] wr_bv_q;
    req_id_t                     rd_id_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_bv_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_id_q   <= '0;
        end else begin
            wr_en_q <= wr_xfer;
            rd_en_q <= rd_xfer;
            if (wr_xfer) begin
                wr_addr_q <= wr_addr_d;
                wr_data_q <= wr_data_d;
                wr_bv_q   <= wr_bv_d;
            end
            if (rd_xfer) begin
                rd_addr_q <= rd_addr_d;
                rd_id_q   <= rd_gid;
            end
        end
    end

    // Owner tag follows each issued read through the RAM latency; reset drops anything in flight.
    logic [RD_LATENCY-1:0] tag_vld_q;
    req_id_t               tag_id_q [RD_LATENCY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_id_q[i] <= '0;
        end else begin
            tag_vld_q[0] <= rd_en_q;
            tag_id_q[0]  <= rd_id_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
        end
    end

    assign rd_data_valid_o = tag_vld_q[RD_LATENCY-1] ? id_to_onehot(tag_id_q[RD_LATENCY-1]) : '0;
    assign rd_data_o       = ram_rd_data_i;

    assign ram_wr_en_o         = wr_en_q;
    assign ram_wr_addr_o       = wr_addr_q;
    assign ram_wr_data_o       = wr_data_q;
    assign ram_wr_byte_valid_o = wr_bv_q;
    assign ram_rd_en_o         = rd_en_q;
    assign ram_rd_addr_o       = rd_addr_q;

`ifdef SDP_RAM_ARB_COLLISION_EN
    logic                  coll_d, coll_q;
    logic [COLL_CNT_W-1:0] coll_cnt_q;

    assign coll_d = wr_xfer & rd_xfer & (wr_addr_d == rd_addr_d);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coll_q     <= 1'b0;
            coll_cnt_q <= '0;
        end else begin
            coll_q <= coll_d;
            if (coll_d && (coll_cnt_q != '1)) begin
                coll_cnt_q <= coll_cnt_q + 1'b1;
            end
        end
    end

    assign collision_o     = coll_q;
    assign collision_cnt_o = coll_cnt_q;
`else
    assign collision_o     = 1'b0;
    assign collision_cnt_o = '0;
`endif
endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Directed bench for sdp_ram_arbiter with a 2-cycle-latency RAM model attached to the RAM ports.
module tb_sdp_ram_arbiter;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int RL = 2;
`ifdef SDP_RAM_ARB_COLLISION_EN
    localparam logic COLL_EN = 1'b1;
`else
    localparam logic COLL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid;
    logic [2*AW-1:0] wr_addr, rd_addr;
    logic [2*DW-1:0] wr_data;
    logic [1:0]    wr_bv;
    logic [DW-1:0] rd_data, ram_wr_data, ram_rd_data;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic          ram_wr_en, ram_rd_en, ram_wr_bv, collision;
    logic [15:0]   collision_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sdp_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .wr_valid_i          (wr_valid),
        .wr_ready_o          (wr_ready),
        .wr_addr_i           (wr_addr),
        .wr_data_i           (wr_data),
        .wr_byte_valid_i     (wr_bv),
        .rd_valid_i          (rd_valid),
        .rd_ready_o          (rd_ready),
        .rd_addr_i           (rd_addr),
        .rd_data_o           (rd_data),
        .rd_data_valid_o     (rd_data_valid),
        .ram_wr_en_o         (ram_wr_en),
        .ram_wr_addr_o       (ram_wr_addr),
        .ram_wr_data_o       (ram_wr_data),
        .ram_wr_byte_valid_o (ram_wr_bv),
        .ram_rd_en_o         (ram_rd_en),
        .ram_rd_addr_o       (ram_rd_addr),
        .ram_rd_data_i       (ram_rd_data),
        .collision_o         (collision),
        .collision_cnt_o     (collision_cnt)
    );

    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (ram_wr_en && ram_wr_bv) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) rd_p1 <= mem[ram_rd_addr];
        rd_p2 <= rd_p1;
    end
    assign ram_rd_data = rd_p2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] wr_v, rd_v, wr_rdy, rd_rdy;
        logic [7:0] waddr, wdata, raddr;
    } vec_t;
    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'b01, 2'b00, 2'b01, 2'b00, 8'h10, 8'hA5, 8'h00};
        vecs[1] = '{2'b11, 2'b11, 2'b10, 2'b01, 8'h21, 8'h5A, 8'h40};
        vecs[2] = '{2'b11, 2'b11, 2'b01, 2'b10, 8'h10, 8'hA5, 8'h41};
        vecs[3] = '{2'b00, 2'b10, 2'b00, 2'b10, 8'h00, 8'h00, 8'h41};
        vecs[4] = '{2'b01, 2'b00, 2'b01, 2'b00, 8'h10, 8'hA5, 8'h00};
        vecs[5] = '{2'b11, 2'b01, 2'b10, 2'b01, 8'h21, 8'h5A, 8'h40};
        vecs[6] = '{2'b11, 2'b11, 2'b01, 2'b10, 8'h10, 8'hA5, 8'h41};
        vecs[7] = '{2'b10, 2'b00, 2'b10, 2'b00, 8'h21, 8'h5A, 8'h00};

        wr_addr = {8'h21, 8'h10};
        wr_data = {8'h5A, 8'hA5};
        wr_bv   = 2'b10;
        rd_addr = {8'h41, 8'h40};

        // Reset state, with requests pending to prove ready stays low.
        rst = 1'b1;
        wr_valid = 2'b11;
        rd_valid = 2'b11;
        #2;
        tick();
        check("rst_wr_ready", wr_ready, 2'b00);
        check("rst_rd_ready", rd_ready, 2'b00);
        check("rst_ram_wr_en", ram_wr_en, 0);
        check("rst_ram_rd_en", ram_rd_en, 0);
        check("rst_rd_data_valid", rd_data_valid, 2'b00);
        check("rst_ram_wr_addr", ram_wr_addr, 0);
        check("rst_ram_wr_data", ram_wr_data, 0);
        check("rst_collision", collision, 0);
        check("rst_collision_cnt", collision_cnt, 0);
        apply_reset();

        for (int i = 0; i < 8; i++) begin
            wr_valid = vecs[i].wr_v;
            rd_valid = vecs[i].rd_v;
            #1;
            check($sformatf("vec%0d_wr_ready", i), wr_ready, vecs[i].wr_rdy);
            check($sformatf("vec%0d_rd_ready", i), rd_ready, vecs[i].rd_rdy);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_ram_wr_en", i), ram_wr_en, |vecs[i].wr_rdy);
            if (vecs[i].wr_rdy != 2'b00) begin
                check($sformatf("vec%0d_ram_wr_addr", i), ram_wr_addr, vecs[i].waddr);
                check($sformatf("vec%0d_ram_wr_data", i), ram_wr_data, vecs[i].wdata);
                check($sformatf("vec%0d_ram_wr_bv", i), ram_wr_bv, vecs[i].wr_rdy[1]);
            end
            check($sformatf("vec%0d_ram_rd_en", i), ram_rd_en, |vecs[i].rd_rdy);
            if (vecs[i].rd_rdy != 2'b00)
                check($sformatf("vec%0d_ram_rd_addr", i), ram_rd_addr, vecs[i].raddr);
        end
        wr_valid = 2'b00;
        rd_valid = 2'b00;

        // Both writers valid for four cycles from reset: alternating grants, no bubbles.
        apply_reset();
        wr_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("b2b%0d_wr_ready", i), wr_ready, (i % 2) ? 2'b10 : 2'b01);
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_ram_wr_en", i), ram_wr_en, 1);
            check($sformatf("b2b%0d_ram_wr_addr", i), ram_wr_addr, (i % 2) ? 8'h21 : 8'h10);
        end
        wr_valid = 2'b00;
        tick();
        check("b2b_idle_ram_wr_en", ram_wr_en, 0);

        // Write 0xA5 to 0x10, then requester 1 reads it back through the 2-cycle RAM.
        apply_reset();
        wr_bv = 2'b11;
        wr_valid = 2'b01;
        tick();
        wr_valid = 2'b00;
        rd_addr = {8'h10, 8'h40};
        rd_valid = 2'b10;
        #1;
        check("rd_ready_req1", rd_ready, 2'b10);
        @(posedge clk);
        #1;
        rd_valid = 2'b00;
        check("rd_t1_ram_rd_en", ram_rd_en, 1);
        check("rd_t1_ram_rd_addr", ram_rd_addr, 8'h10);
        check("rd_t1_valid", rd_data_valid, 2'b00);
        tick();
        check("rd_t2_ram_rd_en", ram_rd_en, 0);
        check("rd_t2_valid", rd_data_valid, 2'b00);
        tick();
        check("rd_t3_valid", rd_data_valid, 2'b10);
        check("rd_t3_data", rd_data, 8'hA5);
        tick();
        check("rd_t4_valid", rd_data_valid, 2'b00);

        // Same-cycle write and read to 0x20, then a non-matching pair.
        apply_reset();
        wr_addr = {8'h21, 8'h20};
        rd_addr = {8'h41, 8'h20};
        wr_valid = 2'b01;
        rd_valid = 2'b01;
        tick();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        check("coll_ram_wr_en", ram_wr_en, 1);
        check("coll_pulse", collision, COLL_EN);
        check("coll_cnt1", collision_cnt, COLL_EN ? 1 : 0);
        tick();
        check("coll_pulse_end", collision, 0);
        wr_valid = 2'b01;
        rd_valid = 2'b10;
        tick();
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        check("nocoll_pulse", collision, 0);
        check("nocoll_cnt", collision_cnt, COLL_EN ? 1 : 0);

        // Reset one cycle after reads are in flight: no data-valid pulse, pointers back to 0.
        apply_reset();
        wr_valid = 2'b11;
        rd_valid = 2'b11;
        tick();
        wr_valid = 2'b00;
        rd_valid = 2'b01;
        tick();
        rd_valid = 2'b11;
        wr_valid = 2'b11;
        rst = 1'b1;
        #1;
        check("midrst_wr_ready", wr_ready, 2'b00);
        check("midrst_rd_ready", rd_ready, 2'b00);
        check("midrst_ram_rd_en", ram_rd_en, 0);
        tick();
        rst = 1'b0;
        wr_valid = 2'b00;
        rd_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("midrst_valid%0d", i), rd_data_valid, 2'b00);
            tick();
        end
        wr_valid = 2'b11;
        rd_valid = 2'b11;
        #1;
        check("midrst_wr_ptr", wr_ready, 2'b01);
        check("midrst_rd_ptr", rd_ready, 2'b01);
        tick();
        wr_valid = 2'b00;
        rd_valid = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
